wb_mem_arbiter: RTL and testbench
=================================

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, max consecutive dcache grants while icache waits before icache is forced ahead (range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: icache  wishbone.slave  bundle  L1 I-cache miss port: CYC, STB, WE, ADR[11:0] line address, SEL[15:0], DAT_M[127:0] in; ACK, RTY, DAT_S[127:0] out.
REQ-005 Port: dcache  wishbone.slave  bundle  L1 D-cache miss/writeback port; same fields as icache.
REQ-006 Port: pmem  wishbone.master  bundle  shared physical memory port; CYC, STB, WE, ADR, SEL, DAT_M out; ACK, RTY, DAT_S in.

Function
REQ-007 States: IDLE, GRANT_I, GRANT_D, TURN; state is registered.
REQ-008 Request: a requester is pending when its CYC and STB are both 1.
REQ-009 IDLE: dcache pending and not forced -> GRANT_D; else icache pending -> GRANT_I; else stay IDLE.
REQ-010 Forced: starve_cnt >= STARVE_LIMIT and icache pending -> GRANT_I regardless of dcache.
REQ-011 starve_cnt (4 bits): +1 on each IDLE->GRANT_D taken while icache pending; cleared on entry to GRANT_I; saturates at 15.
REQ-012 GRANT_x: pmem CYC/STB/WE/ADR/SEL/DAT_M are combinational copies of granted master; non-granted master fields ignored.
REQ-013 IDLE and TURN: pmem CYC=0, STB=0, WE=0, ADR=0, SEL=0, DAT_M=0.
REQ-014 pmem ACK in GRANT_x: routed to granted master same cycle; state -> TURN next edge.
REQ-015 pmem RTY in GRANT_x: routed to granted master same cycle; state -> TURN; no automatic retry.
REQ-016 Non-granted master: ACK=0, RTY=0 at all times.
REQ-017 DAT_S of both masters = pmem DAT_S (shared, valid only with own ACK).
REQ-018 Abort: granted master drops CYC before ACK -> pmem CYC/STB drop same cycle; state -> TURN; late pmem ACK ignored.
REQ-019 TURN: exactly one cycle, then IDLE; guarantees STB low for >=1 cycle between transactions.
REQ-020 Latency: request raised in cycle N while IDLE -> pmem STB high in cycle N+1; back-to-back grants separated by 2 idle bus cycles (TURN, IDLE).
REQ-021 Simultaneous ACK and requester CYC drop: ACK still forwarded, normal TURN path.
REQ-022 Grant is never switched while in GRANT_x, regardless of other requester.

Reset
REQ-023 rst_n=0 asynchronously: state=IDLE, starve_cnt=0; pmem CYC/STB=0 immediately, including mid-transaction.
REQ-024 Both masters' ACK=0, RTY=0 during reset; first arbitration on first clk edge after rst_n=1.

Structure
REQ-025 State enum arb_state_t and STARVE_CNT_WIDTH=4 live in package lc3b_types.
REQ-026 One sub-module wb_arb_pick: combinational next-grant selection from pending bits, starve_cnt, STARVE_LIMIT.
REQ-027 Datapath mux and FSM in wb_mem_arbiter; no buffering of data.

Verification
REQ-028 Only icache requests ADR=0x012, pmem ACK 3 cycles later -> pmem STB high cycle N+1, icache ACK with DAT_S, dcache ACK=0 throughout.
REQ-029 Both request in same IDLE cycle -> dcache granted first; icache granted after TURN+IDLE; icache waits exactly one transaction.
REQ-030 dcache continuously requesting, icache pending, STARVE_LIMIT=4 -> grants D,D,D,D,I; starve_cnt returns to 0.
REQ-031 rst_n low 2 cycles during GRANT_D with pmem STB high -> pmem CYC/STB 0 same cycle; after release state IDLE, no stale ACK to dcache.
REQ-032 pmem RTY during GRANT_I -> icache RTY=1 one cycle, pmem STB low next cycle, re-request re-arbitrated normally.
REQ-033 dcache drops CYC mid-grant, pmem ACK next cycle -> ACK not forwarded to either master; bus returns to IDLE via TURN.

Source files
------------

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and widths for the L1 miss-port arbiter.
package lc3b_types;

    localparam int unsigned STARVE_CNT_WIDTH = 4;
    localparam int unsigned WB_ADR_W         = 12;
    localparam int unsigned WB_SEL_W         = 16;
    localparam int unsigned WB_DAT_W         = 128;

    typedef enum logic [1:0] {
        StIdle,
        StGrantI,
        StGrantD,
        StTurn
    } arb_state_t;

    // Result of one arbitration decision taken in StIdle.
    typedef enum logic [1:0] {
        GntNone,
        GntI,
        GntD
    } grant_t;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone-style cache-line bus between an L1 cache and memory.
interface wishbone;

    logic                           cyc;
    logic                           stb;
    logic                           we;
    logic [lc3b_types::WB_ADR_W-1:0] adr;
    logic [lc3b_types::WB_SEL_W-1:0] sel;
    logic [lc3b_types::WB_DAT_W-1:0] dat_m;
    logic                           ack;
    logic                           rty;
    logic [lc3b_types::WB_DAT_W-1:0] dat_s;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  ack, rty, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output ack, rty, dat_s
    );

endinterface

// File: rtl/wb_mem_arbiter_pick.sv
// Next-grant selection: dcache wins unless icache has waited too long.
module wb_arb_pick
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        i_ipend,
    input  logic                        i_dpend,
    input  logic [STARVE_CNT_WIDTH-1:0] i_starve_cnt,
    output grant_t                      o_grant
);

    localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_CNT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    logic w_forced;

    assign w_forced = i_ipend && (i_starve_cnt >= LIMIT_CNT);

    // Priority pick; a starved icache overrides the dcache preference.
    always_comb begin
        o_grant = GntNone;
        if (i_dpend && !w_forced) begin
            o_grant = GntD;
        end else if (i_ipend) begin
            o_grant = GntI;
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master arbiter sharing one physical memory port between the L1 caches.
module wb_mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    wishbone.slave  icache,
    wishbone.slave  dcache,
    wishbone.master pmem
);

    arb_state_t                  r_state;
    logic [STARVE_CNT_WIDTH-1:0] r_starve_cnt;
    logic                        w_ipend;
    logic                        w_dpend;
    logic                        w_i_done;
    logic                        w_d_done;
    grant_t                      w_pick;

    assign w_ipend = icache.cyc & icache.stb;
    assign w_dpend = dcache.cyc & dcache.stb;

    // A grant ends on ack, retry, or the owner abandoning its cycle.
    assign w_i_done = pmem.ack | pmem.rty | ~icache.cyc;
    assign w_d_done = pmem.ack | pmem.rty | ~dcache.cyc;

    wb_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_ipend      (w_ipend),
        .i_dpend      (w_dpend),
        .i_starve_cnt (r_starve_cnt),
        .o_grant      (w_pick)
    );

    // Grant FSM and icache starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_starve_cnt <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pick == GntD) begin
                        r_state <= StGrantD;
                        if (w_ipend && (r_starve_cnt != '1)) begin
                            r_starve_cnt <= r_starve_cnt + STARVE_CNT_WIDTH'(1);
                        end
                    end else if (w_pick == GntI) begin
                        r_state      <= StGrantI;
                        r_starve_cnt <= '0;
                    end
                end
                StGrantI: if (w_i_done) r_state <= StTurn;
                StGrantD: if (w_d_done) r_state <= StTurn;
                StTurn:   r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    // Unbuffered datapath mux; the bus is quiet outside a grant.
    always_comb begin
        pmem.cyc   = 1'b0;
        pmem.stb   = 1'b0;
        pmem.we    = 1'b0;
        pmem.adr   = '0;
        pmem.sel   = '0;
        pmem.dat_m = '0;
        icache.ack = 1'b0;
        icache.rty = 1'b0;
        dcache.ack = 1'b0;
        dcache.rty = 1'b0;
        unique case (r_state)
            StGrantI: begin
                pmem.cyc   = icache.cyc;
                pmem.stb   = icache.stb;
                pmem.we    = icache.we;
                pmem.adr   = icache.adr;
                pmem.sel   = icache.sel;
                pmem.dat_m = icache.dat_m;
                icache.ack = pmem.ack;
                icache.rty = pmem.rty;
            end
            StGrantD: begin
                pmem.cyc   = dcache.cyc;
                pmem.stb   = dcache.stb;
                pmem.we    = dcache.we;
                pmem.adr   = dcache.adr;
                pmem.sel   = dcache.sel;
                pmem.dat_m = dcache.dat_m;
                dcache.ack = pmem.ack;
                dcache.rty = pmem.rty;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign icache.dat_s = pmem.dat_s;
    assign dcache.dat_s = pmem.dat_s;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a cycle-level reference model.
module tb_wb_mem_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam byte CH_I = 8'h49;
    localparam byte CH_D = 8'h44;

    logic clk;
    logic rst_n;

    wishbone ic();
    wishbone dc();
    wishbone pm();

    wb_mem_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .icache (ic),
        .dcache (dc),
        .pmem   (pm)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who owns the bus, whether a turnaround cycle is due, and
    // how many dcache grants icache has sat through.
    int m_owner;   // 0 none, 1 icache, 2 dcache
    int m_gap;
    int m_starve;
    logic m_ip, m_dp;
    assign m_ip = ic.cyc & ic.stb;
    assign m_dp = dc.cyc & dc.stb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner  <= 0;
            m_gap    <= 0;
            m_starve <= 0;
        end else if (m_gap != 0) begin
            m_gap <= 0;
        end else if (m_owner == 0) begin
            if (m_dp && !(m_ip && m_starve >= int'(LIMIT))) begin
                m_owner <= 2;
                if (m_ip) m_starve <= (m_starve >= 15) ? 15 : m_starve + 1;
            end else if (m_ip) begin
                m_owner  <= 1;
                m_starve <= 0;
            end
        end else if (pm.ack || pm.rty || !((m_owner == 1) ? ic.cyc : dc.cyc)) begin
            m_owner <= 0;
            m_gap   <= 1;
        end
    end

    logic          mi, md;
    logic          e_cyc, e_stb, e_we;
    logic [11:0]   e_adr;
    logic [15:0]   e_sel;
    logic [127:0]  e_dat;
    assign mi    = (m_owner == 1);
    assign md    = (m_owner == 2);
    assign e_cyc = mi ? ic.cyc   : md ? dc.cyc   : 1'b0;
    assign e_stb = mi ? ic.stb   : md ? dc.stb   : 1'b0;
    assign e_we  = mi ? ic.we    : md ? dc.we    : 1'b0;
    assign e_adr = mi ? ic.adr   : md ? dc.adr   : 12'h0;
    assign e_sel = mi ? ic.sel   : md ? dc.sel   : 16'h0;
    assign e_dat = mi ? ic.dat_m : md ? dc.dat_m : 128'h0;

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_pm_cyc", pm.cyc, e_cyc);
        chk("cmp_pm_stb", pm.stb, e_stb);
        chk("cmp_pm_we", pm.we, e_we);
        chk("cmp_pm_adr", pm.adr, e_adr);
        chk("cmp_pm_sel", pm.sel, e_sel);
        chk("cmp_pm_datm", pm.dat_m, e_dat);
        chk("cmp_ic_ack", ic.ack, mi & pm.ack);
        chk("cmp_ic_rty", ic.rty, mi & pm.rty);
        chk("cmp_dc_ack", dc.ack, md & pm.ack);
        chk("cmp_dc_rty", dc.rty, md & pm.rty);
        chk("cmp_ic_dats", ic.dat_s, pm.dat_s);
        chk("cmp_dc_dats", dc.dat_s, pm.dat_s);
    end

    // Log of DUT grants, taken from the address appearing on a new bus cycle.
    byte  glog[$];
    logic prev_cyc = 1'b0;
    always @(negedge clk) begin
        if (pm.cyc && !prev_cyc) glog.push_back((pm.adr == ic.adr) ? CH_I : CH_D);
        prev_cyc <= pm.cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ireq(input logic [11:0] a);
        ic.cyc = 1'b1; ic.stb = 1'b1; ic.we = 1'b0; ic.adr = a; ic.sel = '1; ic.dat_m = '0;
    endtask

    task automatic dreq(input logic [11:0] a, input logic w, input logic [127:0] d);
        dc.cyc = 1'b1; dc.stb = 1'b1; dc.we = w; dc.adr = a; dc.sel = 16'h00ff; dc.dat_m = d;
    endtask

    task automatic idrop();
        ic.cyc = 1'b0; ic.stb = 1'b0;
    endtask

    task automatic ddrop();
        dc.cyc = 1'b0; dc.stb = 1'b0;
    endtask

    string exp_s;

    initial begin
        rst_n = 1'b1;
        ic.cyc = 0; ic.stb = 0; ic.we = 0; ic.adr = 0; ic.sel = 0; ic.dat_m = 0;
        dc.cyc = 0; dc.stb = 0; dc.we = 0; dc.adr = 0; dc.sel = 0; dc.dat_m = 0;
        pm.ack = 0; pm.rty = 0; pm.dat_s = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_pm_cyc", pm.cyc, 1'b0);
        chk("rst_ic_ack", ic.ack, 1'b0);
        rst_n = 1'b1;
        tick();

        // Lone icache read: strobe one cycle later, ack and data forwarded.
        ireq(12'h012);
        #1 chk("a_stb_idle", pm.stb, 1'b0);
        tick();
        chk("a_stb_n1", pm.stb, 1'b1);
        chk("a_adr", pm.adr, 12'h012);
        tick(); tick();
        pm.ack = 1'b1; pm.dat_s = 128'hdead_beef_cafe_f00d_1234_5678_9abc_def0;
        #1;
        chk("a_ic_ack", ic.ack, 1'b1);
        chk("a_ic_dat", ic.dat_s, 128'hdead_beef_cafe_f00d_1234_5678_9abc_def0);
        chk("a_dc_ack", dc.ack, 1'b0);
        tick();
        pm.ack = 1'b0; idrop();
        #1 chk("a_turn_stb", pm.stb, 1'b0);

        // Simultaneous requests: dcache first, icache after TURN and IDLE.
        tick();
        ireq(12'h100);
        dreq(12'h200, 1'b1, 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa);
        tick();
        chk("b_first_d", pm.adr, 12'h200);
        chk("b_we", pm.we, 1'b1);
        pm.ack = 1'b1;
        tick();
        pm.ack = 1'b0; ddrop();
        #1 chk("b_turn", pm.cyc, 1'b0);
        tick();
        chk("b_idle", pm.cyc, 1'b0);
        tick();
        chk("b_second_i", pm.adr, 12'h100);
        pm.ack = 1'b1;
        tick();
        pm.ack = 1'b0; idrop();

        // Starvation: dcache never lets go, icache forced in after four grants.
        tick(); tick();
        glog.delete();
        dreq(12'h300, 1'b0, '0);
        ireq(12'h040);
        for (int i = 1; i <= 32; i++) begin
            tick();
            pm.ack = pm.stb;
            if (i == 12) chk("c_model_starve4", 32'(m_starve), 32'd4);
            if (i == 13) chk("c_model_starve0", 32'(m_starve), 32'd0);
        end
        pm.ack = 1'b0; idrop(); ddrop();
        exp_s = "DDDDIDDDDI";
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("c_grant%0d", i), (i < glog.size()) ? glog[i] : 8'h3f, exp_s[i]);
        end

        // Reset asserted mid-grant: bus drops at once, no stale ack afterwards.
        tick(); tick();
        dreq(12'h2a0, 1'b0, '0);
        tick();
        chk("d_stb_pre", pm.stb, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("d_cyc_rst", pm.cyc, 1'b0);
        chk("d_stb_rst", pm.stb, 1'b0);
        pm.ack = 1'b1; ddrop();
        tick(); tick();
        rst_n = 1'b1;
        #1 chk("d_ack_rel", dc.ack, 1'b0);
        tick();
        chk("d_ack_after", dc.ack, 1'b0);
        chk("d_idle", pm.cyc, 1'b0);
        pm.ack = 1'b0;

        // Retry: forwarded for one cycle, then a normal re-arbitration.
        tick();
        ireq(12'h0e0);
        tick();
        pm.rty = 1'b1;
        #1;
        chk("e_ic_rty", ic.rty, 1'b1);
        chk("e_ic_ack", ic.ack, 1'b0);
        tick();
        pm.rty = 1'b0;
        #1 chk("e_stb_low", pm.stb, 1'b0);
        tick();
        tick();
        chk("e_regrant", pm.stb, 1'b1);
        pm.ack = 1'b1;
        tick();
        pm.ack = 1'b0; idrop();

        // Abort: owner drops CYC, the late ack goes nowhere.
        tick(); tick();
        dreq(12'h3c0, 1'b0, '0);
        tick();
        ddrop();
        #1 chk("f_abort_cyc", pm.cyc, 1'b0);
        tick();
        pm.ack = 1'b1;
        #1;
        chk("f_dc_ack", dc.ack, 1'b0);
        chk("f_ic_ack", ic.ack, 1'b0);
        tick();
        pm.ack = 1'b0;

        // Ack coinciding with CYC drop is still delivered.
        tick();
        dreq(12'h3d0, 1'b0, '0);
        tick();
        pm.ack = 1'b1; ddrop();
        #1 chk("g_dc_ack", dc.ack, 1'b1);
        tick();
        pm.ack = 1'b0;
        #1 chk("g_turn", pm.cyc, 1'b0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
